// File: rtl/status_flags.sv
// 6502 processor status register (P) with the NMI/IRQ front end that feeds the sequencer.
// P is latched from ALU/data-bus results per FLAG_OP; interrupts are synchronised, edge-detected and polled.
module status_flags #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_P     = 8'h34
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ce,
  input  logic [3:0] i_flag_op,
  input  logic       i_alu_n,
  input  logic       i_alu_z,
  input  logic       i_alu_c,
  input  logic       i_alu_v,
  input  logic [7:0] i_db_in,
  input  logic       i_bit_z,
  input  logic       i_poll,
  input  logic       i_int_ack,
  input  logic       i_nmi_n,
  input  logic       i_irq_n,
  output logic [7:0] o_p_out,
  output logic [7:0] o_p_int,
  output logic       o_flag_c,
  output logic       o_flag_d,
  output logic       o_int_pend,
  output logic       o_int_is_nmi,
  output logic [2:0] o_dbg_irq_state
);

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_NZCV    = 4'd1;
  localparam logic [3:0] OP_NZC     = 4'd2;
  localparam logic [3:0] OP_NZ      = 4'd3;
  localparam logic [3:0] OP_LOAD    = 4'd4;
  localparam logic [3:0] OP_BIT     = 4'd5;
  localparam logic [3:0] OP_PULL    = 4'd6;
  localparam logic [3:0] OP_SEC     = 4'd7;
  localparam logic [3:0] OP_CLC     = 4'd8;
  localparam logic [3:0] OP_SED     = 4'd9;
  localparam logic [3:0] OP_CLD     = 4'd10;
  localparam logic [3:0] OP_SEI     = 4'd11;
  localparam logic [3:0] OP_CLI     = 4'd12;
  localparam logic [3:0] OP_CLV     = 4'd13;
  localparam logic [3:0] OP_INT_SEI = 4'd14;

  // Status flags held as individual bits; bits 5 and 4 of P do not exist in hardware.
  logic r_n, r_v, r_d, r_i, r_z, r_c;
  logic w_n_nxt, w_v_nxt, w_d_nxt, w_i_nxt, w_z_nxt, w_c_nxt;

  logic [SYNC_STAGES-1:0] r_nmi_sync;
  logic [SYNC_STAGES-1:0] r_irq_sync;
  logic                   r_nmi_prev;
  logic                   r_nmi_pending;
  logic                   r_i_mask;
  logic                   r_int_pend;
  logic                   r_int_is_nmi;

  logic w_nmi_synced;
  logic w_irq_synced;
  logic w_nmi_edge;
  logic w_nmi_clr;
  logic w_irq_req;
  logic w_unused_db;

  assign w_unused_db = &{1'b0, i_db_in[5:4]};

  always_comb begin
    w_n_nxt = r_n;
    w_v_nxt = r_v;
    w_d_nxt = r_d;
    w_i_nxt = r_i;
    w_z_nxt = r_z;
    w_c_nxt = r_c;
    case (i_flag_op)
      OP_NZCV: begin
        w_n_nxt = i_alu_n;
        w_z_nxt = i_alu_z;
        w_c_nxt = i_alu_c;
        w_v_nxt = i_alu_v;
      end
      OP_NZC: begin
        w_n_nxt = i_alu_n;
        w_z_nxt = i_alu_z;
        w_c_nxt = i_alu_c;
      end
      OP_NZ: begin
        w_n_nxt = i_alu_n;
        w_z_nxt = i_alu_z;
      end
      OP_LOAD: begin
        w_n_nxt = i_db_in[7];
        w_z_nxt = (i_db_in == 8'h00);
      end
      OP_BIT: begin
        w_n_nxt = i_db_in[7];
        w_v_nxt = i_db_in[6];
        w_z_nxt = i_bit_z;
      end
      OP_PULL: begin
        w_n_nxt = i_db_in[7];
        w_v_nxt = i_db_in[6];
        w_d_nxt = i_db_in[3];
        w_i_nxt = i_db_in[2];
        w_z_nxt = i_db_in[1];
        w_c_nxt = i_db_in[0];
      end
      OP_SEC:     w_c_nxt = 1'b1;
      OP_CLC:     w_c_nxt = 1'b0;
      OP_SED:     w_d_nxt = 1'b1;
      OP_CLD:     w_d_nxt = 1'b0;
      OP_SEI:     w_i_nxt = 1'b1;
      OP_CLI:     w_i_nxt = 1'b0;
      OP_CLV:     w_v_nxt = 1'b0;
      OP_INT_SEI: w_i_nxt = 1'b1;
      OP_NOP:     ;
      default:    ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n <= RESET_P[7];
      r_v <= RESET_P[6];
      r_d <= RESET_P[3];
      r_i <= RESET_P[2];
      r_z <= RESET_P[1];
      r_c <= RESET_P[0];
    end else if (i_ce) begin
      r_n <= w_n_nxt;
      r_v <= w_v_nxt;
      r_d <= w_d_nxt;
      r_i <= w_i_nxt;
      r_z <= w_z_nxt;
      r_c <= w_c_nxt;
    end
  end

  // Pin synchronisers and NMI edge detector run every cycle so an NMI is never lost during RDY stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_nmi_sync <= '1;
      r_irq_sync <= '1;
      r_nmi_prev <= 1'b1;
    end else begin
      r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], i_nmi_n};
      r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], i_irq_n};
      r_nmi_prev <= w_nmi_synced;
    end
  end

  assign w_nmi_synced = r_nmi_sync[SYNC_STAGES-1];
  assign w_irq_synced = r_irq_sync[SYNC_STAGES-1];
  assign w_nmi_edge   = r_nmi_prev & ~w_nmi_synced;
  assign w_irq_req    = ~w_irq_synced & ~r_i_mask;
  assign w_nmi_clr    = i_ce & i_int_ack & r_int_pend & r_int_is_nmi;

  // A fresh edge in the same cycle as the acknowledge keeps the NMI pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_nmi_pending <= 1'b0;
    end else begin
      r_nmi_pending <= w_nmi_edge | (r_nmi_pending & ~w_nmi_clr);
    end
  end

  // Sequencer handshake: POLL samples the request at the last instruction cycle, INT_ACK retires it;
  // both qualified by CE, and ACK wins when both are high. i_mask lags I by one poll (NMOS behaviour).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_int_pend   <= 1'b0;
      r_int_is_nmi <= 1'b0;
      r_i_mask     <= 1'b1;
    end else if (i_ce) begin
      if (i_int_ack) begin
        r_int_pend <= 1'b0;
      end else if (i_poll) begin
        r_int_pend   <= r_nmi_pending | w_irq_req;
        r_int_is_nmi <= r_nmi_pending;
      end
      if (i_poll) begin
        r_i_mask <= r_i;
      end
    end
  end

  assign o_p_out         = {r_n, r_v, 1'b1, 1'b1, r_d, r_i, r_z, r_c};
  assign o_p_int         = {r_n, r_v, 1'b1, 1'b0, r_d, r_i, r_z, r_c};
  assign o_flag_c        = r_c;
  assign o_flag_d        = r_d;
  assign o_int_pend      = r_int_pend;
  assign o_int_is_nmi    = r_int_is_nmi;
  assign o_dbg_irq_state = {r_nmi_pending, r_i_mask, r_int_pend};

endmodule

// File: tb/tb_status_flags.sv
// Directed bench for status_flags: flag operations, IRQ masking latency, NMI edge handling, CE gating, reset.
module tb_status_flags;

  logic       clk = 1'b0;
  logic       rst, ce, alu_n, alu_z, alu_c, alu_v, bit_z, poll, ack, nmi_n, irq_n;
  logic [3:0] flag_op;
  logic [7:0] db_in;
  logic [7:0] p_out, p_int;
  logic       flag_c, flag_d, int_pend, int_is_nmi;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] f;
    logic [7:0] db;
    logic [3:0] nzcv;
    logic       bz;
    logic [7:0] exp;
  } vec_t;

  status_flags #(.SYNC_STAGES(2), .RESET_P(8'h34)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_flag_op(flag_op),
    .i_alu_n(alu_n), .i_alu_z(alu_z), .i_alu_c(alu_c), .i_alu_v(alu_v),
    .i_db_in(db_in), .i_bit_z(bit_z), .i_poll(poll), .i_int_ack(ack),
    .i_nmi_n(nmi_n), .i_irq_n(irq_n),
    .o_p_out(p_out), .o_p_int(p_int), .o_flag_c(flag_c), .o_flag_d(flag_d),
    .o_int_pend(int_pend), .o_int_is_nmi(int_is_nmi), .o_dbg_irq_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_op(input logic [3:0] f, input logic [7:0] db, input logic [3:0] nzcv, input logic bz);
    flag_op = f;
    db_in = db;
    {alu_n, alu_z, alu_c, alu_v} = nzcv;
    bit_z = bz;
    cyc(1);
    flag_op = 4'd0;
  endtask

  task automatic poll_once();
    poll = 1'b1;
    cyc(1);
    poll = 1'b0;
  endtask

  task automatic ack_once();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    n_checks++;
    if (p_out !== 8'h34) begin n_errors++; $display("FAIL reset_p_out got %h exp %h", p_out, 8'h34); end
    n_checks++;
    if (p_int !== 8'h24) begin n_errors++; $display("FAIL reset_p_int got %h exp %h", p_int, 8'h24); end
    n_checks++;
    if ({flag_c, flag_d, int_pend, int_is_nmi} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_flags got %b exp %b", {flag_c, flag_d, int_pend, int_is_nmi}, 4'b0000);
    end
    n_checks++;
    if (dbg_state !== 3'b010) begin n_errors++; $display("FAIL reset_dbg got %b exp %b", dbg_state, 3'b010); end
    poll_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL reset_irq_masked got %b exp %b", int_pend, 1'b0); end
  endtask

  task automatic test_alu_ops();
    vec_t tbl [11];
    tbl[0]  = '{4'd1,  8'h00, 4'b1011, 1'b0, 8'hF5};
    tbl[1]  = '{4'd8,  8'h00, 4'b0000, 1'b0, 8'hF4};
    tbl[2]  = '{4'd2,  8'h00, 4'b0110, 1'b0, 8'h77};
    tbl[3]  = '{4'd3,  8'h00, 4'b1000, 1'b0, 8'hF5};
    tbl[4]  = '{4'd13, 8'h00, 4'b0000, 1'b0, 8'hB5};
    tbl[5]  = '{4'd4,  8'h00, 4'b1111, 1'b0, 8'h37};
    tbl[6]  = '{4'd4,  8'h80, 4'b0100, 1'b0, 8'hB5};
    tbl[7]  = '{4'd9,  8'h00, 4'b0000, 1'b0, 8'hBD};
    tbl[8]  = '{4'd10, 8'h00, 4'b0000, 1'b0, 8'hB5};
    tbl[9]  = '{4'd15, 8'hFF, 4'b1111, 1'b1, 8'hB5};
    tbl[10] = '{4'd0,  8'h00, 4'b0100, 1'b1, 8'hB5};
    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].f, tbl[i].db, tbl[i].nzcv, tbl[i].bz);
      n_checks++;
      if (p_out !== tbl[i].exp) begin
        n_errors++; $display("FAIL alu_op%0d step%0d got %h exp %h", tbl[i].f, i, p_out, tbl[i].exp);
      end
      if (i == 7) begin
        n_checks++;
        if (flag_d !== 1'b1) begin n_errors++; $display("FAIL flag_d_sed got %b exp %b", flag_d, 1'b1); end
      end
    end
    n_checks++;
    if ({flag_c, flag_d} !== 2'b10) begin n_errors++; $display("FAIL flag_c_d got %b exp %b", {flag_c, flag_d}, 2'b10); end
  endtask

  task automatic test_load_ops();
    vec_t tbl [9];
    tbl[0] = '{4'd6,  8'h00, 4'b0000, 1'b0, 8'h30};
    tbl[1] = '{4'd5,  8'hC0, 4'b0000, 1'b1, 8'hF2};
    tbl[2] = '{4'd6,  8'hFF, 4'b0000, 1'b0, 8'hFF};
    tbl[3] = '{4'd12, 8'h00, 4'b0000, 1'b0, 8'hFB};
    tbl[4] = '{4'd14, 8'h00, 4'b0000, 1'b0, 8'hFF};
    tbl[5] = '{4'd6,  8'h00, 4'b0000, 1'b0, 8'h30};
    tbl[6] = '{4'd7,  8'h00, 4'b0000, 1'b0, 8'h31};
    tbl[7] = '{4'd8,  8'h00, 4'b0000, 1'b0, 8'h30};
    tbl[8] = '{4'd11, 8'h00, 4'b0000, 1'b0, 8'h34};
    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].f, tbl[i].db, tbl[i].nzcv, tbl[i].bz);
      n_checks++;
      if (p_out !== tbl[i].exp) begin
        n_errors++; $display("FAIL load_op%0d step%0d got %h exp %h", tbl[i].f, i, p_out, tbl[i].exp);
      end
      n_checks++;
      if (p_int !== (tbl[i].exp & 8'hEF)) begin
        n_errors++; $display("FAIL load_p_int step%0d got %h exp %h", i, p_int, tbl[i].exp & 8'hEF);
      end
    end
  endtask

  task automatic test_irq_mask();
    do_op(4'd12, 8'h00, 4'b0000, 1'b0);
    poll_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL cli_first_poll got %b exp %b", int_pend, 1'b0); end
    poll_once();
    n_checks++;
    if ({int_pend, int_is_nmi} !== 2'b10) begin
      n_errors++; $display("FAIL cli_second_poll got %b exp %b", {int_pend, int_is_nmi}, 2'b10);
    end
    do_op(4'd11, 8'h00, 4'b0000, 1'b0);
    poll_once();
    n_checks++;
    if (int_pend !== 1'b1) begin n_errors++; $display("FAIL sei_first_poll got %b exp %b", int_pend, 1'b1); end
    poll_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL sei_second_poll got %b exp %b", int_pend, 1'b0); end
  endtask

  task automatic test_irq_release();
    do_op(4'd12, 8'h00, 4'b0000, 1'b0);
    poll_once();
    poll_once();
    irq_n = 1'b1;
    cyc(4);
    n_checks++;
    if (int_pend !== 1'b1) begin n_errors++; $display("FAIL irq_release_hold got %b exp %b", int_pend, 1'b1); end
    ack_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL irq_ack got %b exp %b", int_pend, 1'b0); end
    poll_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL irq_gone_poll got %b exp %b", int_pend, 1'b0); end
    do_op(4'd11, 8'h00, 4'b0000, 1'b0);
    poll_once();
    irq_n = 1'b0;
    cyc(3);
  endtask

  task automatic test_nmi();
    do_op(4'd12, 8'h00, 4'b0000, 1'b0);
    poll_once();
    nmi_n = 1'b0;
    cyc(4);
    poll_once();
    n_checks++;
    if ({int_pend, int_is_nmi} !== 2'b11) begin
      n_errors++; $display("FAIL nmi_wins got %b exp %b", {int_pend, int_is_nmi}, 2'b11);
    end
    ack_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL nmi_ack got %b exp %b", int_pend, 1'b0); end
    cyc(3);
    poll_once();
    n_checks++;
    if ({int_pend, int_is_nmi} !== 2'b10) begin
      n_errors++; $display("FAIL nmi_level_no_repeat got %b exp %b", {int_pend, int_is_nmi}, 2'b10);
    end
    ack_once();
    do_op(4'd11, 8'h00, 4'b0000, 1'b0);
    poll_once();
    poll_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL nmi_masked_after got %b exp %b", int_pend, 1'b0); end
  endtask

  task automatic test_poll_ack_together();
    nmi_n = 1'b1;
    cyc(4);
    nmi_n = 1'b0;
    cyc(4);
    poll_once();
    n_checks++;
    if ({int_pend, int_is_nmi} !== 2'b11) begin
      n_errors++; $display("FAIL pa_nmi_pend got %b exp %b", {int_pend, int_is_nmi}, 2'b11);
    end
    poll = 1'b1;
    ack = 1'b1;
    cyc(1);
    poll = 1'b0;
    ack = 1'b0;
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL pa_ack_wins got %b exp %b", int_pend, 1'b0); end
    poll_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL pa_nmi_cleared got %b exp %b", int_pend, 1'b0); end
  endtask

  task automatic test_ce_gate();
    nmi_n = 1'b1;
    cyc(4);
    ce = 1'b0;
    flag_op = 4'd7;
    poll = 1'b1;
    nmi_n = 1'b0;
    cyc(6);
    n_checks++;
    if (p_out !== 8'h34) begin n_errors++; $display("FAIL ce_p_hold got %h exp %h", p_out, 8'h34); end
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL ce_pend_hold got %b exp %b", int_pend, 1'b0); end
    ce = 1'b1;
    flag_op = 4'd0;
    cyc(1);
    poll = 1'b0;
    n_checks++;
    if ({int_pend, int_is_nmi} !== 2'b11) begin
      n_errors++; $display("FAIL ce_nmi_reported got %b exp %b", {int_pend, int_is_nmi}, 2'b11);
    end
    ack_once();
  endtask

  task automatic test_back_to_back();
    nmi_n = 1'b1;
    cyc(4);
    nmi_n = 1'b0;
    cyc(4);
    poll_once();
    nmi_n = 1'b1;
    cyc(4);
    nmi_n = 1'b0;
    cyc(2);
    ack_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL b2b_ack got %b exp %b", int_pend, 1'b0); end
    poll_once();
    n_checks++;
    if ({int_pend, int_is_nmi} !== 2'b11) begin
      n_errors++; $display("FAIL b2b_new_nmi_kept got %b exp %b", {int_pend, int_is_nmi}, 2'b11);
    end
    ack_once();
    poll_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL b2b_drained got %b exp %b", int_pend, 1'b0); end
  endtask

  task automatic test_reset_mid();
    nmi_n = 1'b1;
    cyc(4);
    nmi_n = 1'b0;
    cyc(4);
    poll_once();
    nmi_n = 1'b1;
    cyc(4);
    do_op(4'd7, 8'h00, 4'b0000, 1'b0);
    n_checks++;
    if ({p_out, int_pend} !== {8'h35, 1'b1}) begin
      n_errors++; $display("FAIL rstmid_setup got %h exp %h", {p_out, int_pend}, {8'h35, 1'b1});
    end
    rst = 1'b1;
    flag_op = 4'd12;
    ack = 1'b1;
    cyc(1);
    rst = 1'b0;
    flag_op = 4'd0;
    ack = 1'b0;
    n_checks++;
    if (p_out !== 8'h34) begin n_errors++; $display("FAIL rstmid_p got %h exp %h", p_out, 8'h34); end
    n_checks++;
    if (dbg_state !== 3'b010) begin n_errors++; $display("FAIL rstmid_dbg got %b exp %b", dbg_state, 3'b010); end
    cyc(3);
    poll_once();
    n_checks++;
    if (int_pend !== 1'b0) begin n_errors++; $display("FAIL rstmid_poll got %b exp %b", int_pend, 1'b0); end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; flag_op = 4'd0; db_in = 8'h00;
    alu_n = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0; bit_z = 1'b0;
    poll = 1'b0; ack = 1'b0; nmi_n = 1'b1; irq_n = 1'b0;
    test_reset();
    test_alu_ops();
    test_load_ops();
    test_irq_mask();
    test_irq_release();
    test_nmi();
    test_poll_ack_together();
    test_ce_gate();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
